// File: rtl/pdm_decimator.sv
// PDM-to-PCM receiver: 3rd-order CIC decimator by R = 2**LOG2_DECIM, one PDM bit per en strobe.
// Optional build macro PDM_DECIM_SIGNED_EN: re-centre the output as two's complement (0.5 density -> 0).
module pdm_decimator #(
    parameter int LOG2_DECIM = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  pdm_in,
    output logic [3*LOG2_DECIM:0] sample_out,
    output logic                  sample_valid
);

    localparam int OUT_W = 3 * LOG2_DECIM + 1;
`ifdef PDM_DECIM_SIGNED_EN
    localparam logic [OUT_W-1:0] SIGN_OFS = {2'b01, {(OUT_W-2){1'b0}}};
`endif

    logic [OUT_W-1:0]      i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
    logic [OUT_W-1:0]      d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
    logic [OUT_W-1:0]      c1, c2, c3;
    logic [OUT_W-1:0]      sample_q, sample_d;
    logic [LOG2_DECIM-1:0] phase_q, phase_d;
    logic                  dec_pend_q, dec_pend_d;
    logic                  valid_q, valid_d;

    // Integrators cascade within one edge: i2 and i3 take the freshly updated stage below.
    always_comb begin
        i1_d       = i1_q;
        i2_d       = i2_q;
        i3_d       = i3_q;
        phase_d    = phase_q;
        dec_pend_d = 1'b0;
        if (en) begin
            i1_d       = i1_q + {{(OUT_W-1){1'b0}}, pdm_in};
            i2_d       = i2_q + i1_d;
            i3_d       = i3_q + i2_d;
            phase_d    = phase_q + {{(LOG2_DECIM-1){1'b0}}, 1'b1};
            dec_pend_d = &phase_q;
        end
    end

    // Comb runs one edge after the decimating edge, so i3_q already holds the last bit.
    always_comb begin
        c1       = i3_q - d1_q;
        c2       = c1 - d2_q;
        c3       = c2 - d3_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        d3_d     = d3_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        if (dec_pend_q) begin
            d1_d     = i3_q;
            d2_d     = c1;
            d3_d     = c2;
`ifdef PDM_DECIM_SIGNED_EN
            sample_d = c3 - SIGN_OFS;
`else
            sample_d = c3;
`endif
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1_q       <= '0;
            i2_q       <= '0;
            i3_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            d3_q       <= '0;
            phase_q    <= '0;
            dec_pend_q <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            i3_q       <= i3_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            d3_q       <= d3_d;
            phase_q    <= phase_d;
            dec_pend_q <= dec_pend_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: reference output is the PDM bit history convolved with the
// length-(3R-2) CIC kernel (three cascaded R-tap boxcars), decimated by R.
module tb_pdm_decimator;

    localparam int LOG2 = 5;
    localparam int R    = 1 << LOG2;
    localparam int W    = 3 * LOG2 + 1;
    localparam int HL   = 3 * R - 2;
`ifdef PDM_DECIM_SIGNED_EN
    localparam longint OFS = longint'(1) << (W - 2);
`else
    localparam longint OFS = 0;
`endif
    localparam logic [W-1:0] FULL = W'((longint'(1) << (W - 1)) - OFS);
    localparam logic [W-1:0] HALF = W'((longint'(1) << (W - 2)) - OFS);
    localparam logic [W-1:0] ZERO = W'(-OFS);

    logic         clk = 1'b0;
    logic         reset, en, pdm_in;
    logic [W-1:0] sample_out;
    logic         sample_valid;

    always #5 clk = ~clk;

    pdm_decimator #(.LOG2_DECIM(LOG2)) dut (
        .clk(clk), .reset(reset), .en(en), .pdm_in(pdm_in),
        .sample_out(sample_out), .sample_valid(sample_valid)
    );

    int           tests = 0;
    int           fails = 0;
    int           ncnt  = 0;
    bit           bits[$];
    int           en_cyc[$];
    int           v_cyc[$];
    logic [W-1:0] v_val[$];
    longint       h[HL];

    // Record accepted bits and produced samples; en seen at negedge n is the edge n+1.
    always @(negedge clk) begin
        ncnt++;
        if (!reset) begin
            if (en) begin
                bits.push_back(pdm_in);
                en_cyc.push_back(ncnt);
            end
            if (sample_valid) begin
                v_cyc.push_back(ncnt);
                v_val.push_back(sample_out);
            end
        end
    end

    task automatic check(input logic [W-1:0] obs, input logic [W-1:0] exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input int obs, input int exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input int k);
        longint s = 0;
        int     n = k * R - 1;
        for (int j = 0; j < HL; j++)
            if (n - j >= 0 && n - j < bits.size())
                s += h[j] * longint'(bits[n - j]);
        return W'(s - OFS);
    endfunction

    task automatic clear_logs();
        bits.delete();
        en_cyc.delete();
        v_cyc.delete();
        v_val.delete();
    endtask

    task automatic pulse(input bit b, input int sp);
        en     = 1'b1;
        pdm_in = b;
        @(posedge clk);
        #1;
        en     = 1'b0;
        pdm_in = 1'($urandom_range(0, 1));
        repeat (sp - 1) begin
            @(posedge clk);
            #1;
            pdm_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic tail();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        en     = 1'b0;
        pdm_in = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check(sample_out, '0, {tag, "_rst_out"});
        check_int(int'(sample_valid), 0, {tag, "_rst_valid"});
        clear_logs();
        reset = 1'b0;
    endtask

    // Compare every logged sample with the kernel model, its latency and the sample count.
    task automatic check_stream(input string tag, input int first_k, input bit use_c,
                                input logic [W-1:0] cexp);
        check_int(v_val.size(), bits.size() / R, {tag, "_count"});
        for (int k = 1; k <= v_val.size(); k++) begin
            if (k >= first_k)
                check(v_val[k-1], model(k), $sformatf("%s_s%0d", tag, k));
            if (use_c && k >= 4)
                check(v_val[k-1], cexp, $sformatf("%s_c%0d", tag, k));
            if (k * R <= en_cyc.size())
                check_int(v_cyc[k-1], en_cyc[k*R-1] + 2, $sformatf("%s_lat%0d", tag, k));
        end
    endtask

    initial begin
        longint h2[2*R-1];
        for (int i = 0; i < 2 * R - 1; i++) h2[i] = 0;
        for (int i = 0; i < HL; i++) h[i] = 0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < R; j++) h2[i+j] += 1;
        for (int i = 0; i < 2 * R - 1; i++)
            for (int j = 0; j < R; j++) h[i+j] += h2[i];

        reset  = 1'b1;
        en     = 1'b0;
        pdm_in = 1'b0;
        do_reset("init");

        for (int i = 0; i < 8 * R; i++) pulse(1'b0, 25);
        tail();
        check_stream("zeros", 1, 1'b1, ZERO);

        do_reset("t2");
        for (int i = 0; i < 8 * R; i++) pulse(1'b1, 1);
        tail();
        check_stream("ones", 4, 1'b1, FULL);

        do_reset("t3");
        for (int i = 0; i < 8 * R; i++) pulse(1'(i % 2 == 0), 25);
        tail();
        check_stream("alt", 4, 1'b1, HALF);

        do_reset("t4");
        for (int i = 0; i < 8 * R; i++) pulse(1'($urandom_range(0, 99) < 70), $urandom_range(1, 6));
        tail();
        check_stream("rand", 4, 1'b0, '0);

        do_reset("t4z");
        for (int i = 0; i < 5 * R; i++) pulse(1'b0, 1);
        tail();
        check_stream("zeros_fast", 1, 1'b1, ZERO);

        // Reset while the comb update is pending: output clears at once and no pulse follows.
        do_reset("t5");
        for (int i = 0; i < 5 * R; i++) pulse(1'b1, 1);
        check(sample_out, FULL, "pre_reset_out");
        #2;
        reset = 1'b1;
        #1;
        check(sample_out, '0, "async_out");
        check_int(int'(sample_valid), 0, "async_valid");
        @(posedge clk);
        #1;
        check_int(int'(sample_valid), 0, "no_spurious_valid");
        clear_logs();
        reset = 1'b0;

        // Reset while valid is high.
        for (int i = 0; i < R; i++) pulse(1'b1, 1);
        @(posedge clk);
        #1;
        check_int(int'(sample_valid), 1, "valid_high");
        check(sample_out, model(1), "valid_high_val");
        #2;
        reset = 1'b1;
        #1;
        check_int(int'(sample_valid), 0, "valid_drop");
        check(sample_out, '0, "valid_drop_out");
        @(posedge clk);
        #1;
        clear_logs();
        reset = 1'b0;

        // Reset mid-frame at phase 17, then one full frame must be needed for the next sample.
        for (int i = 0; i < 17; i++) pulse(1'b1, 25);
        reset = 1'b1;
        #1;
        check_int(int'(sample_valid), 0, "mid_valid");
        @(posedge clk);
        #1;
        clear_logs();
        reset = 1'b0;
        for (int i = 0; i < R - 1; i++) pulse(1'b1, 25);
        check_int(v_val.size(), 0, "early_valid");
        pulse(1'b1, 25);
        tail();
        check_stream("restart", 1, 1'b0, '0);

        do_reset("t6");
        for (int i = 0; i < 200; i++) pulse(1'b1, $urandom_range(1, 40));
        tail();
        check_stream("gaps", 4, 1'b1, FULL);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
